// File: rtl/cond_unit_if.sv
// Signal bundle between the decode/execute stage and the ARMv4 condition unit.
// The master side drives the decoder requests and ALU flags; the slave side
// (cond_unit) returns the gated write enables and the architectural NZCV.
interface cond_unit_if;
   logic       en;
   logic [3:0] cond;
   logic [3:0] alu_flags;
   logic [1:0] flag_w;
   logic       pcs_in;
   logic       reg_w_in;
   logic       mem_w_in;
   logic       no_write_in;

   logic       pcs;
   logic       reg_w;
   logic       mem_w;
   logic       cond_ex;
   logic       undef_cond;
   logic [3:0] flags;

   modport master (
      output en, cond, alu_flags, flag_w, pcs_in, reg_w_in, mem_w_in, no_write_in,
      input  pcs, reg_w, mem_w, cond_ex, undef_cond, flags
   );

   modport slave (
      input  en, cond, alu_flags, flag_w, pcs_in, reg_w_in, mem_w_in, no_write_in,
      output pcs, reg_w, mem_w, cond_ex, undef_cond, flags
   );
endinterface

// File: rtl/cond_unit.sv
// ARMv4 condition unit: evaluates the instruction condition field against the
// architectural NZCV register, gates the PC/register/memory writes, and
// updates the NZ and CV flag fields independently.
//
// cond_ex is derived only from the registered flags, so a flag-setting
// instruction affects the condition of the following instruction, never its
// own (no bypass from alu_flags).
module cond_unit (
   input  logic        clk,
   input  logic        reset,
   cond_unit_if.slave  bus
);

   typedef enum logic [3:0] {
      CC_EQ = 4'b0000,
      CC_NE = 4'b0001,
      CC_CS = 4'b0010,
      CC_CC = 4'b0011,
      CC_MI = 4'b0100,
      CC_PL = 4'b0101,
      CC_VS = 4'b0110,
      CC_VC = 4'b0111,
      CC_HI = 4'b1000,
      CC_LS = 4'b1001,
      CC_GE = 4'b1010,
      CC_LT = 4'b1011,
      CC_GT = 4'b1100,
      CC_LE = 4'b1101,
      CC_AL = 4'b1110,
      CC_NV = 4'b1111
   } cond_code_t;

   logic [1:0] nz_q;
   logic [1:0] cv_q;

   logic       flag_n;
   logic       flag_z;
   logic       flag_c;
   logic       flag_v;

   logic       cond_pass;
   logic       cond_undef;
   logic       write_ok;
   logic       upd_nz;
   logic       upd_cv;

   assign flag_n = nz_q[1];
   assign flag_z = nz_q[0];
   assign flag_c = cv_q[1];
   assign flag_v = cv_q[0];

   // Condition decode against the pre-update flag register.
   always_comb begin
      cond_pass  = 1'b0;
      cond_undef = 1'b0;
      unique case (cond_code_t'(bus.cond))
         CC_EQ: cond_pass = flag_z;
         CC_NE: cond_pass = ~flag_z;
         CC_CS: cond_pass = flag_c;
         CC_CC: cond_pass = ~flag_c;
         CC_MI: cond_pass = flag_n;
         CC_PL: cond_pass = ~flag_n;
         CC_VS: cond_pass = flag_v;
         CC_VC: cond_pass = ~flag_v;
         CC_HI: cond_pass = flag_c & ~flag_z;
         CC_LS: cond_pass = ~flag_c | flag_z;
         CC_GE: cond_pass = (flag_n == flag_v);
         CC_LT: cond_pass = (flag_n != flag_v);
         CC_GT: cond_pass = ~flag_z & (flag_n == flag_v);
         CC_LE: cond_pass = flag_z | (flag_n != flag_v);
         CC_AL: cond_pass = 1'b1;
         CC_NV: begin
            cond_pass  = 1'b0;
            cond_undef = 1'b1;
         end
         default: begin
            cond_pass  = 1'b0;
            cond_undef = 1'b0;
         end
      endcase
   end

   // Write gating: a stalled or condition-failed instruction has no side effects.
   // Compare-class ops still set flags but never write the register file.
   always_comb begin
      write_ok = cond_pass & bus.en;
      upd_nz   = write_ok & bus.flag_w[1];
      upd_cv   = write_ok & bus.flag_w[0];
   end

   assign bus.cond_ex    = cond_pass;
   assign bus.undef_cond = cond_undef;
   assign bus.pcs        = bus.pcs_in   & write_ok;
   assign bus.mem_w      = bus.mem_w_in & write_ok;
   assign bus.reg_w      = bus.reg_w_in & write_ok & ~bus.no_write_in;
   assign bus.flags      = {nz_q, cv_q};

   // NZ field: reset clears, otherwise loads from the ALU when selected.
   always_ff @(posedge clk) begin
      if (reset) begin
         nz_q <= 2'b00;
      end else if (upd_nz) begin
         nz_q <= bus.alu_flags[3:2];
      end
   end

   // CV field: independent of NZ so shifts/logical ops can leave C,V intact.
   always_ff @(posedge clk) begin
      if (reset) begin
         cv_q <= 2'b00;
      end else if (upd_cv) begin
         cv_q <= bus.alu_flags[1:0];
      end
   end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: decode table at several flag values, write
// gating, split flag-field updates, stall, undefined condition and reset.
module tb_cond_unit;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   cond_unit_if bus ();

   cond_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af);
      bus.cond      = c;
      bus.flag_w    = fw;
      bus.alu_flags = af;
      #1;
   endtask

   task automatic set_flags(input logic [3:0] f);
      bus.en = 1'b1;
      drive(4'b1110, 2'b11, f);
      tick();
      chk("set_flags", {12'd0, bus.flags}, {12'd0, f});
   endtask

   task automatic sweep(input string tag, input logic [15:0] exp_mask);
      logic [15:0] got;
      got = '0;
      for (int i = 0; i < 16; i++) begin
         drive(i[3:0], 2'b00, 4'b0000);
         got[i] = bus.cond_ex;
      end
      chk(tag, got, exp_mask);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.en = 1'b1;
      bus.pcs_in = 1'b0;
      bus.reg_w_in = 1'b1;
      bus.mem_w_in = 1'b0;
      bus.no_write_in = 1'b0;
      drive(4'b0000, 2'b00, 4'b0000);
      tick();
      chk("rst_flags", {12'd0, bus.flags}, 16'h0000);
      chk("rst_eq_cex", {15'd0, bus.cond_ex}, 16'd0);
      chk("rst_eq_regw", {15'd0, bus.reg_w}, 16'd0);
      reset = 1'b0;
      drive(4'b0001, 2'b00, 4'b0000);
      chk("ne_cex", {15'd0, bus.cond_ex}, 16'd1);
      chk("ne_regw", {15'd0, bus.reg_w}, 16'd1);
      bus.no_write_in = 1'b1;
      #1;
      chk("nowrite_regw", {15'd0, bus.reg_w}, 16'd0);
      bus.no_write_in = 1'b0;

      // No bypass: EQ sees old Z=0 even while ALU reports Z=1.
      drive(4'b0000, 2'b11, 4'b0100);
      chk("no_bypass", {15'd0, bus.cond_ex}, 16'd0);
      drive(4'b1110, 2'b11, 4'b0100);
      tick();
      chk("al_upd", {12'd0, bus.flags}, 16'h0004);
      bus.pcs_in = 1'b1;
      drive(4'b0000, 2'b00, 4'b0000);
      chk("eq_after", {15'd0, bus.cond_ex}, 16'd1);
      chk("pcs_on", {15'd0, bus.pcs}, 16'd1);
      bus.pcs_in = 1'b0;
      #1;
      chk("pcs_off", {15'd0, bus.pcs}, 16'd0);

      // Split field updates; compare-class op still sets flags.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2", {12'd0, bus.flags}, 16'h0000);
      drive(4'b1110, 2'b10, 4'b1011);
      tick();
      chk("nz_only", {12'd0, bus.flags}, 16'h0008);
      bus.no_write_in = 1'b1;
      drive(4'b1110, 2'b01, 4'b0111);
      tick();
      chk("cv_only", {12'd0, bus.flags}, 16'h000B);
      bus.no_write_in = 1'b0;

      // Full decode table, hand-computed masks (bit i = cond i passes).
      set_flags(4'b0110);
      sweep("tbl_0110", 16'h66A5);
      set_flags(4'b1001);
      sweep("tbl_1001", 16'h565A);
      set_flags(4'b0010);
      sweep("tbl_0010", 16'h55A6);

      set_flags(4'b1001);
      drive(4'b1010, 2'b00, 4'b0000);
      chk("ge_1001", {15'd0, bus.cond_ex}, 16'd1);
      drive(4'b1011, 2'b00, 4'b0000);
      chk("lt_1001", {15'd0, bus.cond_ex}, 16'd0);
      drive(4'b1100, 2'b00, 4'b0000);
      chk("gt_1001", {15'd0, bus.cond_ex}, 16'd1);
      set_flags(4'b1000);
      drive(4'b1010, 2'b00, 4'b0000);
      chk("ge_1000", {15'd0, bus.cond_ex}, 16'd0);
      drive(4'b1011, 2'b00, 4'b0000);
      chk("lt_1000", {15'd0, bus.cond_ex}, 16'd1);
      drive(4'b1101, 2'b00, 4'b0000);
      chk("le_1000", {15'd0, bus.cond_ex}, 16'd1);

      // Failed condition suppresses writes and flag update.
      set_flags(4'b1001);
      bus.pcs_in = 1'b1;
      bus.reg_w_in = 1'b1;
      bus.mem_w_in = 1'b1;
      drive(4'b0000, 2'b11, 4'b1111);
      chk("fail_memw", {15'd0, bus.mem_w}, 16'd0);
      chk("fail_wr", {14'd0, bus.pcs, bus.reg_w}, 16'd0);
      tick();
      chk("fail_hold", {12'd0, bus.flags}, 16'h0009);

      // Stall: condition still evaluates but nothing is written.
      bus.en = 1'b0;
      drive(4'b1110, 2'b11, 4'b0110);
      chk("stall_cex", {15'd0, bus.cond_ex}, 16'd1);
      chk("stall_wr", {13'd0, bus.pcs, bus.reg_w, bus.mem_w}, 16'd0);
      tick();
      chk("stall_hold", {12'd0, bus.flags}, 16'h0009);
      bus.en = 1'b1;

      // Undefined condition field.
      drive(4'b1111, 2'b11, 4'b0110);
      chk("nv_undef", {15'd0, bus.undef_cond}, 16'd1);
      chk("nv_cex", {15'd0, bus.cond_ex}, 16'd0);
      chk("nv_wr", {13'd0, bus.pcs, bus.reg_w, bus.mem_w}, 16'd0);
      tick();
      chk("nv_hold", {12'd0, bus.flags}, 16'h0009);
      drive(4'b1110, 2'b00, 4'b0000);
      chk("al_undef", {15'd0, bus.undef_cond}, 16'd0);

      // Reset wins over a concurrent update; stream resumes from 0000.
      reset = 1'b1;
      drive(4'b1110, 2'b11, 4'b1111);
      tick();
      chk("rst_wins", {12'd0, bus.flags}, 16'h0000);
      reset = 1'b0;
      drive(4'b0000, 2'b00, 4'b0000);
      chk("post_rst_eq", {15'd0, bus.cond_ex}, 16'd0);
      drive(4'b0001, 2'b00, 4'b0000);
      chk("post_rst_ne", {15'd0, bus.cond_ex}, 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
